// File: rtl/coil_pulse_sequencer.sv
// Coil pulse-train sequencer: ON/OFF repetitions on InVGSf/InVGSr with a flyback guard
// on direction reversal. Define COIL_SEQ_PULSE_CNT_EN to add the pulse_count output.
module coil_pulse_sequencer #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_on,
    input  logic [CNT_W-1:0] cmd_off,
    input  logic [CNT_W-1:0] cmd_reps,
    input  logic             abort,
    output logic             InVGSf,
    output logic             InVGSr,
    output logic             busy,
    output logic             done
`ifdef COIL_SEQ_PULSE_CNT_EN
    ,
    output logic [15:0]      pulse_count
`endif
);

    localparam int unsigned FB_W   = CNT_W + 1;
    localparam int unsigned FB_MAX = (1 << FB_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_ON,
        S_OFF
    } state_t;

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             last_dir_q, last_dir_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] off_q, off_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [FB_W-1:0]  fb_q, fb_d;
    logic [FB_W-1:0]  fb_load;
    logic [31:0]      fb_sum;
    logic             fwd_q, fwd_d;
    logic             rev_q, rev_d;
    logic             done_q, done_d;
    logic             rep_step;

    assign cmd_ready = (state_q == S_IDLE) && !abort;
    assign busy      = (state_q != S_IDLE);
    assign InVGSf    = fwd_q;
    assign InVGSr    = rev_q;
    assign done      = done_q;

    // ph_q holds the elapsed ON cycles including the current one, so it is the flyback base.
    always_comb begin
        fb_sum  = 32'(ph_q) + 32'(GUARD_CYC);
        fb_load = (fb_sum > FB_MAX) ? FB_W'(FB_MAX) : FB_W'(fb_sum);
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        on_d       = on_q;
        off_d      = off_q;
        reps_d     = reps_q;
        ph_d       = ph_q;
        rep_d      = rep_q;
        done_d     = 1'b0;
        rep_step   = 1'b0;
        fb_d       = (fb_q != '0) ? fb_q - 1'b1 : fb_q;

        if (abort) begin
            if (state_q == S_ON) begin
                fb_d = fb_load;
            end
            state_d = S_IDLE;
            ph_d    = '0;
            rep_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dir_d  = cmd_dir;
                        on_d   = cmd_on;
                        off_d  = cmd_off;
                        reps_d = cmd_reps;
                        if (cmd_on == '0 || cmd_reps == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rep_d = CNT_W'(1);
                            ph_d  = CNT_W'(1);
                            if (cmd_dir != last_dir_q && fb_q != '0) begin
                                state_d = S_GUARD;
                            end else begin
                                state_d    = S_ON;
                                last_dir_d = cmd_dir;
                            end
                        end
                    end
                end
                S_GUARD: begin
                    if (fb_q == '0) begin
                        state_d    = S_ON;
                        last_dir_d = dir_q;
                    end
                end
                S_ON: begin
                    if (ph_q == on_q) begin
                        fb_d = fb_load;
                        ph_d = CNT_W'(1);
                        if (off_q != '0) begin
                            state_d = S_OFF;
                        end else begin
                            rep_step = 1'b1;
                        end
                    end else begin
                        ph_d = ph_q + CNT_W'(1);
                    end
                end
                S_OFF: begin
                    if (ph_q == off_q) begin
                        ph_d     = CNT_W'(1);
                        rep_step = 1'b1;
                    end else begin
                        ph_d = ph_q + CNT_W'(1);
                    end
                end
            endcase

            if (rep_step) begin
                if (rep_q == reps_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    ph_d    = '0;
                    rep_d   = '0;
                end else begin
                    state_d    = S_ON;
                    rep_d      = rep_q + CNT_W'(1);
                    last_dir_d = dir_q;
                end
            end
        end

        fwd_d = (state_d == S_ON) && dir_d;
        rev_d = (state_d == S_ON) && !dir_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b1;
            last_dir_q <= 1'b1;
            on_q       <= '0;
            off_q      <= '0;
            reps_q     <= '0;
            ph_q       <= '0;
            rep_q      <= '0;
            fb_q       <= '0;
            fwd_q      <= 1'b0;
            rev_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            on_q       <= on_d;
            off_q      <= off_d;
            reps_q     <= reps_d;
            ph_q       <= ph_d;
            rep_q      <= rep_d;
            fb_q       <= fb_d;
            fwd_q      <= fwd_d;
            rev_q      <= rev_d;
            done_q     <= done_d;
        end
    end

`ifdef COIL_SEQ_PULSE_CNT_EN
    logic [15:0] pcnt_q;
    logic        on_done;

    assign on_done     = (state_q == S_ON) && (ph_q == on_q) && !abort;
    assign pulse_count = pcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else if (on_done && pcnt_q != '1) begin
            pcnt_q <= pcnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coil_pulse_sequencer.sv
// Self-checking bench for coil_pulse_sequencer: vector table, corner-case sequences,
// and random command streams checked against an arithmetic timeline model.
`timescale 1ns/1ps
module tb_coil_pulse_sequencer;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned GUARD_CYC = 4;
    localparam int          G         = int'(GUARD_CYC);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_dir = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cmd_on = '0;
    logic [CNT_W-1:0] cmd_off = '0;
    logic [CNT_W-1:0] cmd_reps = '0;
    logic             cmd_ready, InVGSf, InVGSr, busy, done;
`ifdef COIL_SEQ_PULSE_CNT_EN
    logic [15:0]      pulse_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    int fh[0:127];
    int rh[0:127];
    int bh[0:127];
    int dh[0:127];
    int rdy[0:127];
    int acc_at[0:3];
    int n_acc;

    coil_pulse_sequencer #(.CNT_W(CNT_W), .GUARD_CYC(GUARD_CYC)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_on(cmd_on), .cmd_off(cmd_off), .cmd_reps(cmd_reps),
        .abort(abort), .InVGSf(InVGSf), .InVGSr(InVGSr), .busy(busy), .done(done)
`ifdef COIL_SEQ_PULSE_CNT_EN
        , .pulse_count(pulse_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int b(input logic v);
        return (v === 1'b1) ? 1 : ((v === 1'b0) ? 0 : -1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (InVGSf === 1'b1 && InVGSr === 1'b1) begin
                n_fail++;
                $display("FAIL mutex at %0t: InVGSf=1 InVGSr=1, expected at most one high", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic d, input int on, input int off, input int reps);
        cmd_valid = 1'b1;
        cmd_dir   = d;
        cmd_on    = CNT_W'(on);
        cmd_off   = CNT_W'(off);
        cmd_reps  = CNT_W'(reps);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        check("rst_f", b(InVGSf), 0);
        check("rst_r", b(InVGSr), 0);
        check("rst_busy", b(busy), 0);
        check("rst_done", b(done), 0);
        check("rst_ready", b(cmd_ready), 1);
        rst = 1'b0;
        tick();
    endtask

    // Cycle 0 presents the first command; a second one is held from cycle sec_from until
    // accepted; abort is high during cycle abort_c. Captures outputs of cycles 0..n.
    task automatic run_seq(input logic d1, input int on1, input int off1, input int reps1,
                           input int sec_from, input logic d2, input int on2, input int off2,
                           input int reps2, input int abort_c, input int n);
        bit acc;
        n_acc = 0;
        if (n > 127) n = 127;
        drive_cmd(d1, on1, off1, reps1);
        for (int c = 0; c <= n; c++) begin
            fh[c] = b(InVGSf);
            rh[c] = b(InVGSr);
            bh[c] = b(busy);
            dh[c] = b(done);
            if (c == sec_from) drive_cmd(d2, on2, off2, reps2);
            abort = (c == abort_c);
            #1;
            rdy[c] = b(cmd_ready);
            acc = cmd_valid && cmd_ready;
            if (acc && n_acc < 4) begin
                acc_at[n_acc] = c;
                n_acc++;
            end
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    typedef struct {
        logic dir;
        int   on;
        int   off;
        int   reps;
        int   exp_high;
        int   exp_first;
        int   exp_done;
    } tv_t;

    initial begin
        tv_t tv[7];
        int  hi, other, first, ndone, dcyc, last_f, first_r, cnt;

        tv[0] = '{1'b1, 5, 5, 3, 15, 1, 31};
        tv[1] = '{1'b0, 3, 0, 2, 6, 1, 7};
        tv[2] = '{1'b1, 0, 7, 4, 0, 0, 1};
        tv[3] = '{1'b0, 4, 2, 0, 0, 0, 1};
        tv[4] = '{1'b1, 1, 1, 1, 1, 1, 3};
        tv[5] = '{1'b0, 2, 3, 2, 4, 1, 11};
        tv[6] = '{1'b1, 7, 0, 1, 7, 1, 8};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_seq(tv[i].dir, tv[i].on, tv[i].off, tv[i].reps, -1, 1'b0, 0, 0, 0, -1,
                    tv[i].exp_done + 3);
            hi = 0; other = 0; first = 0; ndone = 0; dcyc = 0;
            for (int c = 1; c <= tv[i].exp_done + 3; c++) begin
                if ((tv[i].dir ? fh[c] : rh[c]) == 1) begin
                    hi++;
                    if (first == 0) first = c;
                end
                if ((tv[i].dir ? rh[c] : fh[c]) != 0) other++;
                if (dh[c] == 1) begin
                    ndone++;
                    dcyc = c;
                end
            end
            check($sformatf("tv%0d_high", i), hi, tv[i].exp_high);
            check($sformatf("tv%0d_first", i), first, tv[i].exp_first);
            check($sformatf("tv%0d_other", i), other, 0);
            check($sformatf("tv%0d_ndone", i), ndone, 1);
            check($sformatf("tv%0d_donecyc", i), dcyc, tv[i].exp_done);
        end

        // fwd on=5 off=5 reps=3, cycle-exact
        do_reset();
        run_seq(1'b1, 5, 5, 3, -1, 1'b0, 0, 0, 0, -1, 33);
        for (int c = 1; c <= 32; c++) begin
            check($sformatf("p533_f_c%0d", c), fh[c],
                  ((c >= 1 && c <= 5) || (c >= 11 && c <= 15) || (c >= 21 && c <= 25)) ? 1 : 0);
            check($sformatf("p533_done_c%0d", c), dh[c], (c == 31) ? 1 : 0);
            check($sformatf("p533_busy_c%0d", c), bh[c], (c <= 30) ? 1 : 0);
        end

        // reversal after long ON must wait for flyback
        do_reset();
        run_seq(1'b1, 30, 2, 1, 1, 1'b0, 5, 0, 1, -1, 90);
        last_f = -1; first_r = -1;
        for (int c = 0; c <= 90; c++) begin
            if (fh[c] == 1) last_f = c;
            if (rh[c] == 1 && first_r < 0) first_r = c;
        end
        check("rev_accept", (n_acc > 1) ? acc_at[1] : -1, 33);
        check("rev_last_f", last_f, 30);
        check("rev_first_r", first_r, 66);
        check("rev_gap_ge_on_plus_guard", (first_r - last_f - 1 >= 30 + G) ? 1 : 0, 1);
        check("rev_busy_guard", bh[50], 1);
        check("rev_quiet_guard", fh[50] + rh[50], 0);

        // same direction never waits
        do_reset();
        run_seq(1'b1, 30, 2, 1, 1, 1'b1, 5, 0, 1, -1, 45);
        check("same_accept", (n_acc > 1) ? acc_at[1] : -1, 33);
        check("same_done1", dh[33], 1);
        check("same_f33", fh[33], 0);
        check("same_f34", fh[34], 1);
        check("same_f38", fh[38], 1);
        check("same_f39", fh[39], 0);
        check("same_done2", dh[39], 1);

        // zero ON count
        do_reset();
        run_seq(1'b1, 0, 3, 4, -1, 1'b0, 0, 0, 0, -1, 6);
        cnt = 0;
        for (int c = 1; c <= 6; c++) cnt += bh[c] + fh[c] + rh[c];
        check("zero_done1", dh[1], 1);
        check("zero_done2", dh[2], 0);
        check("zero_quiet", cnt, 0);

        // abort in cycle 10 of fwd on=20, then reverse
        do_reset();
        run_seq(1'b1, 20, 0, 1, 11, 1'b0, 5, 0, 1, 10, 40);
        first_r = -1; ndone = 0;
        for (int c = 0; c <= 40; c++) begin
            if (rh[c] == 1 && first_r < 0) first_r = c;
            if (c <= 25 && dh[c] == 1) ndone++;
        end
        check("abort_f10", fh[10], 1);
        check("abort_f11", fh[11], 0);
        check("abort_ready10", rdy[10], 0);
        check("abort_busy11", bh[11], 0);
        check("abort_nodone", ndone, 0);
        check("abort_accept2", (n_acc > 1) ? acc_at[1] : -1, 11);
        check("abort_busy12", bh[12], 1);
        check("abort_first_r", first_r, 11 + 10 + G + 1);

        // abort and command in the same idle cycle
        do_reset();
        run_seq(1'b1, 3, 0, 1, -1, 1'b0, 0, 0, 0, 0, 6);
        check("abwin_ready0", rdy[0], 0);
        check("abwin_busy1", bh[1], 0);
        check("abwin_f1", fh[1], 0);
        check("abwin_accept", (n_acc > 0) ? acc_at[0] : -1, 1);
        check("abwin_f2", fh[2], 1);

        // reset mid-ON of a reverse train
        do_reset();
        drive_cmd(1'b0, 15, 0, 1);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("rstmid_r_before", b(InVGSr), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_r", b(InVGSr), 0);
        check("rstmid_f", b(InVGSf), 0);
        check("rstmid_busy", b(busy), 0);
        check("rstmid_done", b(done), 0);
        check("rstmid_ready", b(cmd_ready), 1);
        tick();
        rst = 1'b0;
        tick();
        run_seq(1'b0, 5, 0, 1, -1, 1'b0, 0, 0, 0, -1, 8);
        check("rstmid_r1", rh[1], 1);
        check("rstmid_r5", rh[5], 1);
        check("rstmid_r6", rh[6], 0);
        check("rstmid_done6", dh[6], 1);

        // random command stream against the timeline model
        begin
            int   A, S, E, Dn, P, ron, roff, rreps, ncmd, c, next_a, h, L, fbv;
            int   eb, eh;
            logic rdir, ldir;
            bit   isnull, hv;
            do_reset();
            A = -10; S = 0; E = -10; Dn = -10; P = 1; ron = 0; rreps = 0;
            rdir = 1'b1; ldir = 1'b1; isnull = 1'b1; hv = 1'b0; h = 0; L = 0;
            ncmd = 0; c = 0; next_a = $urandom_range(0, 2);
            while ((ncmd < 40 || c <= Dn + 1) && c < 6000) begin
                eb = (!isnull && c > A && c <= E) ? 1 : 0;
                eh = (!isnull && c > S && c <= E && ((c - S - 1) % P) < ron) ? 1 : 0;
                check($sformatf("rnd_f_c%0d", c), b(InVGSf), (eh == 1 && rdir) ? 1 : 0);
                check($sformatf("rnd_r_c%0d", c), b(InVGSr), (eh == 1 && !rdir) ? 1 : 0);
                check($sformatf("rnd_busy_c%0d", c), b(busy), eb);
                check($sformatf("rnd_done_c%0d", c), b(done), (c == Dn) ? 1 : 0);
                check($sformatf("rnd_ready_c%0d", c), b(cmd_ready), 1 - eb);
                if (ncmd < 40 && c == next_a) begin
                    rdir  = 1'($urandom_range(0, 1));
                    ron   = $urandom_range(0, 12);
                    roff  = $urandom_range(0, 6);
                    rreps = $urandom_range(0, 3);
                    A = c;
                    isnull = (ron == 0 || rreps == 0);
                    if (isnull) begin
                        Dn = A + 1;
                    end else begin
                        fbv = hv ? (L - (A - h - 1)) : 0;
                        if (fbv < 0) fbv = 0;
                        P = ron + roff;
                        S = A + ((rdir != ldir && fbv > 0) ? fbv : 0);
                        E = S + rreps * P;
                        Dn = E + 1;
                        ldir = rdir;
                        hv = 1'b1;
                        h = S + (rreps - 1) * P + ron;
                        L = (ron + G > 511) ? 511 : ron + G;
                    end
                    next_a = Dn + $urandom_range(0, 2);
                    drive_cmd(rdir, ron, roff, rreps);
                    ncmd++;
                end else if (eb == 1 && $urandom_range(0, 1) == 1) begin
                    drive_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 255),
                              $urandom_range(0, 255), $urandom_range(0, 255));
                end else begin
                    cmd_valid = 1'b0;
                end
                tick();
                c++;
            end
            cmd_valid = 1'b0;
            check("rnd_within_budget", (c < 6000) ? 1 : 0, 1);
            check("rnd_cmds_issued", ncmd, 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/coil_pulse_sequencer.md
COIL_PULSE_SEQUENCER -- requirements
Module: coil_pulse_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of on/off/repeat fields.
REQ-002 SHALL have parameter GUARD_CYC, default 4: extra flyback cycles added after every ON phase.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  pulse-train command present.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_dir  input  1  direction: 1 = forward, 0 = reverse.
REQ-008 SHALL have port cmd_on  input  CNT_W  ON cycles per repetition.
REQ-009 SHALL have port cmd_off  input  CNT_W  OFF cycles per repetition.
REQ-010 SHALL have port cmd_reps  input  CNT_W  repetition count.
REQ-011 SHALL have port abort  input  1  synchronous cancel of the current train.
REQ-012 SHALL have port InVGSf  output  1  forward drive request to H-bridge controller.
REQ-013 SHALL have port InVGSr  output  1  reverse drive request to H-bridge controller.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a train completes normally.

Function
REQ-016 SHALL implement states IDLE, GUARD, ON, OFF; cmd_ready = (state==IDLE) && !abort.
REQ-017 SHALL accept a command on a rising edge where cmd_valid && cmd_ready, latching dir/on/off/reps.
REQ-018 SHALL, on accept with cmd_on==0 or cmd_reps==0, stay IDLE, drive no output, pulse done the following cycle.
REQ-019 SHALL, on accept with cmd_dir != last_dir and fb_cnt != 0, enter GUARD; otherwise enter ON directly.
REQ-020 SHALL leave GUARD for ON on the edge after fb_cnt reaches 0.
REQ-021 SHALL drive the selected output (InVGSf or InVGSr) high for exactly cmd_on consecutive cycles per repetition, registered, first high cycle = cycle after ON entry edge.
REQ-022 SHALL follow each ON with cmd_off low cycles (OFF skipped if cmd_off==0), including after the last repetition.
REQ-023 SHALL, after the last OFF, return to IDLE and pulse done for exactly one cycle, coincident with cmd_ready returning high.
REQ-024 SHALL keep a flyback counter fb_cnt of CNT_W+1 bits, loaded with min(on_elapsed+GUARD_CYC, all-ones) on the cycle after every ON phase ends, decrementing by 1 each cycle while nonzero in any state.
REQ-025 SHALL update last_dir on every ON entry; same-direction commands never wait for fb_cnt.
REQ-026 SHALL never assert InVGSf and InVGSr in the same cycle.
REQ-027 SHALL, on abort in any state, go to IDLE on the next edge with both outputs low, no done pulse; an abort during ON loads fb_cnt with elapsed ON cycles + GUARD_CYC.
REQ-028 SHALL ignore cmd_valid in every state other than IDLE; abort and accept in the same cycle: abort wins, command not accepted.

Reset
REQ-029 SHALL, while rst is high, force state IDLE, InVGSf=0, InVGSr=0, busy=0, done=0, fb_cnt=0, last_dir=1, repetition and phase counters 0.
REQ-030 SHALL, on rst asserted mid-ON, drop the active output asynchronously; after release cmd_ready=1 and no guard is applied.

Configuration
REQ-031 SHALL, with macro COIL_SEQ_PULSE_CNT_EN defined, add output pulse_count (16 bits) counting completed ON phases, saturating at 16'hFFFF, cleared by rst.
REQ-032 SHALL, without COIL_SEQ_PULSE_CNT_EN, omit the pulse_count port and its logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: fwd on=5 off=5 reps=3 -> InVGSf high in cycles 1-5, 11-15, 21-25 after accept; done pulses in cycle 31.
REQ-034 SHALL cover: fwd on=30 off=2 reps=1 then rev on=5 off=0 reps=1 offered immediately -> at least 34 low cycles between last InVGSf high and first InVGSr high; busy high during GUARD.
REQ-035 SHALL cover: fwd on=30 off=2 reps=1 then fwd on=5 off=0 reps=1 -> no GUARD; InVGSf high again the cycle after the second command is accepted.
REQ-036 SHALL cover: cmd_on=0 reps=4 -> no output, done pulse one cycle after accept, busy stays 0.
REQ-037 SHALL cover: abort in cycle 10 of fwd on=20 -> InVGSf low next cycle, no done, following rev command waits 10+GUARD_CYC cycles.
REQ-038 SHALL cover: rst pulse mid-ON of rev on=15 -> InVGSr low immediately, all outputs at reset values, next rev command starts without guard.
